// File: rtl/ksa.sv
// ksa -- RC4 key-scheduling stage.
//
// Permutes the 256-byte S state held in an external single-port synchronous
// RAM, in place, under a KEYLEN-byte key. When rdy returns high, S holds the
// scheduled permutation consumed by the downstream PRGA stage.
//
// Optional feature macro: KSA_INIT_EN
//   defined   : an INIT phase writes S[k]=k for k=0..255 before scheduling
//               (rdy low for 1792 cycles per run).
//   undefined : S must already hold the identity permutation (rdy low for
//               1536 cycles per run).
//
// Ports:
//   clk     in   1          single clock, rising edge
//   rst     in   1          asynchronous active-high reset
//   en      in   1          start request, sampled only while rdy=1
//   rdy     out  1          idle and able to accept en
//   key     in   8*KEYLEN   RC4 key, byte 0 = most significant byte
//   addr    out  8          S RAM address
//   rddata  in   8          S RAM read data, valid the cycle after a read addr
//   wrdata  out  8          S RAM write data
//   wren    out  1          S RAM write enable
//
// Handshake: a start is accepted on any rising edge where en=1 and rdy=1.
// The key is latched on that edge and rdy drops in the next cycle. en seen
// while rdy=0 is ignored; a level-held en is simply accepted again on the
// first cycle rdy is high (no bubble between back-to-back runs).
module ksa #(
  parameter int KEYLEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  rdy,
  input  logic [8*KEYLEN-1:0]   key,
  output logic [7:0]            addr,
  input  logic [7:0]            rddata,
  output logic [7:0]            wrdata,
  output logic                  wren
);

  localparam int KW = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;
  localparam logic [KW-1:0] KIDX_LAST = KW'(KEYLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RD_SI,
    S_CAP_SI,
    S_RD_SJ,
    S_CAP_SJ,
    S_WR_I,
    S_WR_J
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [7:0]            i;
  logic [7:0]            j;
  logic [7:0]            si;
  logic [7:0]            sj;
  logic [KW-1:0]         kidx;
  logic [8*KEYLEN-1:0]   key_q;
  logic [7:0]            key_byte;

  // Key byte for the current iteration; kidx tracks i mod KEYLEN directly
  // so no divider is needed. Byte 0 sits in the most significant lane.
  always_comb begin
    key_byte = key_q[(KEYLEN - 1 - int'(kidx)) * 8 +: 8];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and RAM-facing outputs.
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    addr      = 8'd0;
    wrdata    = 8'd0;
    wren      = 1'b0;
    case (state)
      S_IDLE: begin
        rdy = 1'b1;
        if (en) begin
`ifdef KSA_INIT_EN
          state_nxt = S_INIT;
`else
          state_nxt = S_RD_SI;
`endif
        end
      end
      S_INIT: begin
        addr   = i;
        wrdata = i;
        wren   = 1'b1;
        if (i == 8'd255) begin
          state_nxt = S_RD_SI;
        end
      end
      S_RD_SI: begin
        addr      = i;
        state_nxt = S_CAP_SI;
      end
      S_CAP_SI: begin
        state_nxt = S_RD_SJ;
      end
      S_RD_SJ: begin
        // j already holds the value updated in CAP_SI.
        addr      = j;
        state_nxt = S_CAP_SJ;
      end
      S_CAP_SJ: begin
        state_nxt = S_WR_I;
      end
      S_WR_I: begin
        addr      = i;
        wrdata    = sj;
        wren      = 1'b1;
        state_nxt = S_WR_J;
      end
      S_WR_J: begin
        // When i==j both writes hit the same address with the same value,
        // so S is left unchanged without any special handling.
        addr   = j;
        wrdata = si;
        wren   = 1'b1;
        if (i == 8'd255) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RD_SI;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i     <= 8'd0;
      j     <= 8'd0;
      si    <= 8'd0;
      sj    <= 8'd0;
      kidx  <= '0;
      key_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            key_q <= key;
            i     <= 8'd0;
            j     <= 8'd0;
            kidx  <= '0;
          end
        end
        S_INIT: begin
          // Wraps 255 -> 0, leaving i ready for the first iteration.
          i <= i + 8'd1;
        end
        S_CAP_SI: begin
          si <= rddata;
          j  <= j + rddata + key_byte;
        end
        S_CAP_SJ: begin
          sj <= rddata;
        end
        S_WR_J: begin
          i <= i + 8'd1;
          if (kidx == KIDX_LAST) begin
            kidx <= '0;
          end else begin
            kidx <= kidx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa.sv
// tb_ksa -- self-checking bench for ksa.
//
// Owns a behavioural model of the S RAM (synchronous read, write at the
// rising edge) and a plain RC4 key-schedule reference computed on an array.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ksa;

`ifdef KSA_INIT_EN
  localparam int LAT    = 1792;
  localparam int INIT_W = 256;
`else
  localparam int LAT    = 1536;
  localparam int INIT_W = 0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        rdy;
  logic [23:0] key = 24'd0;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  always #5 clk = ~clk;

  ksa #(.KEYLEN(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  // ---------------- S RAM model ----------------
  logic [7:0] mem [256];
  logic [7:0] pre [256];
  logic       load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= pre[k];
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  // ---------------- cycle counter and write monitor ----------------
  int cyc = 0;
  int acc_cyc = 0;
  int wr_cnt = 0;
  int         wr_cyc_q [$];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wren) begin
      wr_cnt++;
      wr_cyc_q.push_back(cyc - acc_cyc + 1);
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(wrdata);
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] ref_s [256];
  logic [7:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RC4 KSA on ref_s, straight from the algorithm definition.
  task automatic ref_ksa(input logic [23:0] k);
    int jj;
    int kb;
    logic [7:0] t;
`ifdef KSA_INIT_EN
    for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
`endif
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      kb = int'((k >> (8 * (2 - (n % 3)))) & 24'hFF);
      jj = (jj + int'(ref_s[n]) + kb) % 256;
      t = ref_s[n];
      ref_s[n] = ref_s[jj];
      ref_s[jj] = t;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_ram(input bit shuffle);
    logic [7:0] t;
    int r;
    for (int k = 0; k < 256; k++) pre[k] = 8'(k);
    if (shuffle) begin
      for (int k = 255; k > 0; k--) begin
        r = $urandom_range(k, 0);
        t = pre[k]; pre[k] = pre[r]; pre[r] = t;
      end
    end
    for (int k = 0; k < 256; k++) ref_s[k] = pre[k];
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic start_run(input logic [23:0] k);
    int guard;
    guard = 0;
    while (!rdy && guard < 5000) begin
      @(negedge clk); guard++;
    end
    check("start_rdy", 32'(rdy), 32'd1);
    key = k;
    en = 1'b1;
    acc_cyc = cyc + 1;
    wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!rdy && lat < 4000) begin
      lat++;
      @(negedge clk);
    end
    check(tag, 32'(lat), 32'(LAT));
  endtask

  task automatic compare_s(input string tag);
    exp_q.delete();
    for (int k = 0; k < 256; k++) exp_q.push_back(ref_s[k]);
    for (int k = 0; k < 256; k++) begin
      check($sformatf("%s[%0d]", tag, k), 32'(mem[k]), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int rises;
    int accepts;
    int low_cnt;
    logic prev_rdy;
    logic [23:0] rk;
    int ti [6];
    int ta [6];
    int td [6];

    // Reset held with en high: nothing may be written.
    en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wren_cnt", 32'(wr_cnt), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wrdata", 32'(wrdata), 32'd0);
    en = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Trace check on key 000018 from identity.
    load_ram(1'b0);
    start_run(24'h000018);
    wait_done("lat_trace");
    ref_ksa(24'h000018);
    ti = '{5, 6, 11, 12, 17, 18};
    ta = '{0, 0, 1, 1, 2, 8'h1B};
    td = '{0, 0, 1, 1, 8'h1B, 2};
    check("trace_nwr", 32'(wr_cyc_q.size()), 32'(INIT_W + 512));
    if (wr_cyc_q.size() >= INIT_W + 6) begin
      for (int n = 0; n < 6; n++) begin
        check($sformatf("trace_cyc%0d", n), 32'(wr_cyc_q[INIT_W + n]), 32'(INIT_W + ti[n]));
        check($sformatf("trace_addr%0d", n), 32'(wr_addr_q[INIT_W + n]), 32'(ta[n]));
        check($sformatf("trace_data%0d", n), 32'(wr_data_q[INIT_W + n]), 32'(td[n]));
      end
    end
    compare_s("s_trace");

    // Full run on key 1E4600.
    load_ram(1'b0);
    start_run(24'h1E4600);
    wait_done("lat_full");
    ref_ksa(24'h1E4600);
    compare_s("s_full");

    // Random keys over random starting permutations.
    for (int r = 0; r < 3; r++) begin
      rk = 24'($urandom);
      load_ram(1'b1);
      start_run(rk);
      wait_done("lat_rand");
      ref_ksa(rk);
      compare_s($sformatf("s_rand%0d", r));
    end

    // en held high across one run boundary: exactly two back-to-back runs.
    load_ram(1'b0);
    wr_cnt = 0;
    rises = 0; accepts = 0; low_cnt = 0;
    prev_rdy = rdy;
    key = 24'h1E4600;
    en = 1'b1;
    for (int c = 0; c < LAT + 200; c++) begin
      if (rdy) accepts++;
      else low_cnt++;
      @(negedge clk);
      if (rdy && !prev_rdy) rises++;
      prev_rdy = rdy;
    end
    en = 1'b0;
    for (int c = 0; c < 2 * LAT && !rdy; c++) begin
      low_cnt++;
      @(negedge clk);
    end
    check("held_accepts", 32'(accepts), 32'd2);
    check("held_rises", 32'(rises), 32'd1);
    check("held_low", 32'(low_cnt), 32'(2 * LAT));
    check("held_wren", 32'(wr_cnt), 32'(2 * (INIT_W + 512)));
    ref_ksa(24'h1E4600);
    ref_ksa(24'h1E4600);
    compare_s("s_held");

    // Async reset in the middle of iteration 100.
    load_ram(1'b0);
    start_run(24'h1E4600);
    repeat (INIT_W + 6 * 100 + 2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_rdy", 32'(rdy), 32'd1);
    check("midrst_wren", 32'(wren), 32'd0);
    check("midrst_addr", 32'(addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_ram(1'b0);
    start_run(24'h000018);
    wait_done("lat_after_rst");
    ref_ksa(24'h000018);
    compare_s("s_after_rst");

    // Key changed one cycle after the start must not matter.
    load_ram(1'b0);
    start_run(24'h3C5A96);
    key = 24'hFFFFFF;
    wait_done("lat_keylatch");
    ref_ksa(24'h3C5A96);
    compare_s("s_keylatch");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
